// File: rtl/axi_lite_write_slave_if.sv
// AXI_LITE bundle: write address/data/response channels plus read-channel tie-off signals.
interface AXI_LITE;
  logic [31:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic        ar_ready;
  logic        r_valid;

  modport Master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_valid
  );

  modport Slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_valid
  );
endinterface

// File: rtl/axi_lite_write_slave.sv
// AXI-Lite write responder with a local 32-bit register bank.
// Optional per-byte strobes: define AXI_WR_SLAVE_STRB_EN (otherwise only strb=4'hF is legal).
module axi_lite_write_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_REGS  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  AXI_LITE.Slave                      axi_slave,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx_i,
  output logic [31:0]                 rd_data_o,
  output logic                        wr_pulse_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx_o
);

  localparam int unsigned IW = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);

  typedef enum logic [1:0] {IDLE, HALF, FULL, RESP} state_t;

  state_t      state, state_next;
  logic        aw_held, w_held;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  b_resp_q;
  logic [31:0] regs [NUM_REGS];

  logic          aw_ready, w_ready, aw_hs, w_hs, commit, err;
  logic [31:0]   off;
  logic [IW-1:0] idx;

  // Readies come only from registered state: no valid-to-ready path.
  assign aw_ready = !aw_held && (state != RESP);
  assign w_ready  = !w_held  && (state != RESP);
  assign aw_hs    = axi_slave.aw_valid && aw_ready;
  assign w_hs     = axi_slave.w_valid  && w_ready;
  assign commit   = (state == FULL);

  assign off = aw_addr_q - BASE_ADDR;
  assign idx = off[2 +: IW];

  always_comb begin
    err = (aw_addr_q < BASE_ADDR) || (off >= SPAN) || (aw_addr_q[1:0] != 2'b00);
`ifndef AXI_WR_SLAVE_STRB_EN
    if (w_strb_q != 4'hF) err = 1'b1;
`endif
  end

  assign axi_slave.aw_ready = aw_ready;
  assign axi_slave.w_ready  = w_ready;
  assign axi_slave.b_valid  = (state == RESP);
  assign axi_slave.b_resp   = b_resp_q;
  assign axi_slave.ar_ready = 1'b0;
  assign axi_slave.r_valid  = 1'b0;

  assign rd_data_o = regs[rd_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (aw_hs && w_hs)      state_next = FULL;
        else if (aw_hs || w_hs) state_next = HALF;
      end
      HALF: if ((aw_held && w_hs) || (w_held && aw_hs)) state_next = FULL;
      FULL: state_next = RESP;
      RESP: if (axi_slave.b_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_resp_q   <= 2'b00;
      wr_pulse_o <= 1'b0;
      wr_idx_o   <= '0;
    end else begin
      wr_pulse_o <= 1'b0;
      if (aw_hs) begin
        aw_addr_q <= axi_slave.aw_addr;
        aw_held   <= 1'b1;
      end
      if (w_hs) begin
        w_data_q <= axi_slave.w_data;
        w_strb_q <= axi_slave.w_strb;
        w_held   <= 1'b1;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        b_resp_q <= err ? 2'b10 : 2'b00;
        if (!err) begin
          wr_pulse_o <= 1'b1;
          wr_idx_o   <= idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && !err) begin
      for (int unsigned k = 0; k < 4; k++)
        if (w_strb_q[k]) regs[idx][8*k +: 8] <= w_data_q[8*k +: 8];
    end
  end

endmodule

// File: doc/axi_lite_write_slave.md
# axi_lite_write_slave

AXI-Lite write responder closing the loop with the control-side AXI-Lite write masters. It accepts the AW and W channels independently and in either order, decodes the address into a local bank of 32-bit registers, commits the write with byte strobes and returns a B response. Register contents are exposed through a combinational read port, and every commit produces a one-cycle write notification for downstream control logic.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of register 0; must be aligned to NUM_REGS*4.
- NUM_REGS, 16, number of 32-bit registers; a power of two, 2..256.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- axi_slave  AXI_LITE.Slave  —  write channels used: aw_addr/aw_valid/aw_ready, w_data/w_strb/w_valid/w_ready, b_resp/b_valid/b_ready. Read channels are tied off: ar_ready=0, r_valid=0.
- rd_idx_i  in  $clog2(NUM_REGS)  register index for the local read port.
- rd_data_o  out  32  combinational contents of register rd_idx_i.
- wr_pulse_o  out  1  one-cycle pulse on each successful commit.
- wr_idx_o  out  $clog2(NUM_REGS)  index of the last committed register; valid while wr_pulse_o=1.

## Operation
- Holding registers:
  - aw_held with aw_addr_q.
  - w_held with w_data_q and w_strb_q.
- aw_ready = !aw_held && !b_valid; w_ready = !w_held && !b_valid. Both are decoded from registered state only, with no combinational path from any valid input.
- AW handshake (aw_valid && aw_ready at an edge): capture the address and set aw_held. W handshake: capture data and strobe, and set w_held. The two handshakes may occur on the same edge or on different edges, in either order.
- Commit on the first edge where aw_held && w_held:
  - off = aw_addr_q - BASE_ADDR; idx = off[2 +: $clog2(NUM_REGS)].
  - Error if aw_addr_q < BASE_ADDR, off >= NUM_REGS*4, or aw_addr_q[1:0] != 0.
  - If there is no error, update bytes k of reg[idx] where w_strb_q[k]=1. Set b_resp=2'b00 (OKAY), wr_pulse_o=1, wr_idx_o=idx.
  - If there is an error, write nothing, set b_resp=2'b10 (SLVERR) and keep wr_pulse_o=0.
  - In both cases set b_valid=1 and clear aw_held and w_held.
- State machine, derived from the flags:
  - IDLE (no hold): go to HALF on one handshake, or to FULL on both.
  - HALF (one held): go to FULL when the missing handshake completes.
  - FULL: always commits and goes to RESP.
  - RESP: b_valid=1 and both readies are 0. Return to IDLE on the edge where b_ready=1.
- b_valid and b_resp hold stable until b_ready. Only one transaction is in flight at a time.
- Register contents are never changed by reads or by SLVERR transactions.

## Timing
- Reset values:
  - aw_ready=1, w_ready=1, b_valid=0, b_resp=2'b00.
  - wr_pulse_o=0, wr_idx_o=0.
  - All registers 0, so rd_data_o=0.
  - Holds cleared.
- Both handshakes on edge E0 → commit, register update and b_valid=1 after edge E1 → earliest B handshake at edge E2. The next AW/W can be accepted at edge E3, giving a throughput of 1 write per 3 cycles.
- Split handshakes (AW at E0, W at Ek with k>0) → commit at Ek+1.
- wr_pulse_o is high for exactly the cycle after the commit edge, coincident with the first cycle of b_valid.
- rd_data_o reflects a commit from the cycle after the commit edge.
- A reset assertion mid-transaction asynchronously drops b_valid and the holds and clears the registers. A pending B response is lost.
- b_ready held high while b_valid=0 has no effect.

## Configuration
- AXI_WR_SLAVE_STRB_EN:
  - Defined: w_strb is honoured per byte, and any strobe value (including 4'h0, which writes nothing but returns OKAY) is legal.
  - Undefined: only w_strb=4'hF is accepted. Any other strobe returns SLVERR with no write and no wr_pulse_o.

## Test plan
- AW and W on the same edge, addr=BASE_ADDR+8, data=32'hDEADBEEF, strb=4'hF → b_valid after 1 cycle with b_resp=00; wr_pulse_o=1 with wr_idx_o=2; rd_idx_i=2 reads 32'hDEADBEEF.
- W first (data=32'h1234_5678), AW 3 cycles later (addr=BASE_ADDR+4) → w_ready stays 0 until the B handshake; the commit happens one edge after AW; reg[1]=32'h12345678.
- Out-of-range write to addr=BASE_ADDR+NUM_REGS*4 and misaligned write to addr=BASE_ADDR+2 → both return b_resp=10, with no wr_pulse_o and all registers unchanged.
- B back-pressure: b_ready held 0 for 5 cycles → b_valid/b_resp stable, aw_ready=w_ready=0 throughout; the next write is accepted 1 cycle after b_ready.
- Strobe: reg[0]=32'hFFFFFFFF, then write 32'h0 with strb=4'b0101 → with AXI_WR_SLAVE_STRB_EN, reg[0]=32'hFF00FF00 and OKAY; without it, SLVERR and reg[0] unchanged.
- rst_n pulsed low while in RESP → b_valid drops immediately, all registers read 0, and aw_ready=w_ready=1 after release.
